if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller for the pipeline front end. Owns the fetch PC and drives it to the BTB lookup (`pc_i`), selects the next PC from redirect, BTB prediction or PC+4, and runs a req/ack handshake to instruction memory. Delivers one instruction per cycle, with its PC and prediction tag, into the IF/ID register under the global hold code. A 1-entry skid buffer absorbs responses that arrive while the stage is held.

## Interface
- `RESET_PC`, 32'h8000_0000, first fetch address after reset (non-zero, since the BTB treats PC 0 as invalid).
- `NOP_INST`, 32'h0000_0013, instruction value presented when no valid instruction is present.
- `clk`  in  1  clock; reset `rst_n`, synchronous, active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `hold_code_i`  in  `BUS_HOLD_CODE`  global stall; stage advances only when equal to `HOLD_CODE_NOPE`.
- `redirect_en_i`  in  1  execute-stage redirect (misprediction or exception); flushes this stage.
- `redirect_pc_i`  in  32  redirect target.
- `pred_jmp_i`  in  1  BTB prediction for the current `pc_o`.
- `pred_target_i`  in  32  BTB predicted target.
- `pc_o`  out  32  current fetch PC, the BTB lookup address.
- `if_req_o`  out  1  memory request.
- `if_addr_o`  out  32  request address; equals `pc_o`.
- `if_ack_i`  in  1  memory response valid, with data in the same cycle.
- `if_data_i`  in  32  fetched instruction.
- `inst_valid_o`  out  1  IF/ID entry valid.
- `inst_o`  out  32  instruction.
- `inst_pc_o`  out  32  PC of `inst_o`.
- `inst_pred_o`  out  1  prediction taken for `inst_o`; travels with the instruction to the BTB check.

## Operation
- States: IDLE, REQ, DROP, STALL. Reset enters IDLE.
- Fetch PC register `fpc`. `pc_o` and `if_addr_o` both equal `fpc`.
- Next PC is `fpc`+4, or `pred_target_i` when `pred_jmp_i`=1. Addition wraps modulo 2^32.
- IDLE: `if_req_o`=0. Moves to REQ on the next cycle.
- REQ: `if_req_o`=1. `if_addr_o` stays stable until `if_ack_i`.
  - On ack without redirect: the instruction, `fpc` and `pred_jmp_i` go to the output register if it advances this cycle; otherwise they go to the skid buffer.
  - After that ack, `fpc` takes the next PC.
  - If the skid buffer is now full, go to STALL; otherwise stay in REQ.
- REQ, redirect without ack: save `redirect_pc_i` as pending and go to DROP. The address must not change mid-request.
- REQ, redirect with ack in the same cycle: discard the data, set `fpc` to `redirect_pc_i`, stay in REQ.
- DROP: `if_req_o`=1 with the old address.
  - On ack, discard the data, set `fpc` to the pending PC, go to REQ.
  - A further redirect while in DROP overwrites the pending PC, including one coincident with the ack.
- STALL: `if_req_o`=0. When hold clears, the skid buffer drains to the output and the state returns to REQ.
- Any redirect clears `inst_valid_o` and the skid buffer in the same edge, in every state. Redirect takes priority over hold.
- Output register update:
  - When hold is clear, it loads the skid buffer if valid, else the accepted ack data, else a bubble (`inst_valid_o`=0, `inst_o`=`NOP_INST`).
  - When hold is set, it keeps its value.

## Timing
- Reset values:
  - `pc_o` = `RESET_PC`.
  - `if_req_o`=0.
  - `inst_valid_o`=0, `inst_o`=`NOP_INST`, `inst_pc_o`=0, `inst_pred_o`=0.
  - Skid buffer empty; state IDLE.
- First `if_req_o`=1 appears in the second cycle after reset release.
- Latency from ack to `inst_valid_o` is 1 cycle when not held.
- With zero-wait memory (ack in the same cycle as req), throughput is 1 instruction per cycle.
- The BTB lookup is combinational on `pc_o`. Prediction and data are sampled at the same ack edge.
- Redirect to first request at the new PC:
  - 1 cycle when the redirect coincides with an ack.
  - Otherwise, the old request's ack followed by 1 cycle.
- Reset mid-request abandons the transaction. The memory side must tolerate the withdrawn request.

## Configuration
- `IFU_BTB_PRED_EN` defined: the next-PC selection uses `pred_jmp_i`/`pred_target_i`, and `inst_pred_o` carries the sampled prediction.
- `IFU_BTB_PRED_EN` undefined:
  - Next PC is always `fpc`+4; prediction inputs are ignored.
  - `inst_pred_o` is constant 0.
  - Every taken branch is corrected by `redirect_en_i`.

## Test plan
- Reset release with ack tied to `if_req_o`, no hold → fetches 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, each valid on `inst_*` one cycle later with `inst_pred_o`=0.
- `pred_jmp_i`=1 with target 0x8000_0100 at `pc_o`=0x8000_0008 (macro defined) → next fetch is 0x8000_0100 and the 0x8000_0008 instruction has `inst_pred_o`=1. With the macro undefined → next fetch is 0x8000_000C and `inst_pred_o`=0.
- Request at 0x8000_0010 stalled by ack low for 3 cycles, redirect to 0x8000_0400 in cycle 1 → address stays 0x8000_0010 until the ack, that data is dropped, next request is 0x8000_0400, and `inst_valid_o` is 0 from the redirect edge.
- Hold asserted for 4 cycles while acks continue → one response lands in the skid buffer, `if_req_o` drops (STALL), the output is frozen; on release the skid item emerges first, then fetch resumes with no loss or duplication.
- Redirect and ack in the same cycle while hold is set → output and skid buffer are flushed, and the next request is the redirect PC.
- `rst_n` low during DROP → all outputs return to their reset values and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, runs the req/ack memory handshake,
// and feeds the IF/ID register through a 1-entry skid buffer. Define IFU_BTB_PRED_EN to enable BTB-driven next-PC.
module if_fetch_ctrl #(
  parameter int unsigned            HOLD_CODE_W    = 3,
  parameter logic [HOLD_CODE_W-1:0] HOLD_CODE_NOPE = '0,
  parameter logic [31:0]            RESET_PC       = 32'h8000_0000,
  parameter logic [31:0]            NOP_INST       = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HOLD_CODE_W-1:0] hold_code_i,
  input  logic                   redirect_en_i,
  input  logic [31:0]            redirect_pc_i,
  input  logic                   pred_jmp_i,
  input  logic [31:0]            pred_target_i,
  output logic [31:0]            pc_o,
  output logic                   if_req_o,
  output logic [31:0]            if_addr_o,
  input  logic                   if_ack_i,
  input  logic [31:0]            if_data_i,
  output logic                   inst_valid_o,
  output logic [31:0]            inst_o,
  output logic [31:0]            inst_pc_o,
  output logic                   inst_pred_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  // One fetched instruction together with its PC and sampled prediction.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            pred;
  } fetch_entry_t;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            req_q, req_d;
  fetch_entry_t    skid_q, skid_d;
  fetch_entry_t    out_q, out_d;

  logic            advance;
  logic            ack_ok;
  logic            pred_take;
  logic [XLEN-1:0] next_pc;
  fetch_entry_t    ack_entry;
  fetch_entry_t    bubble;

`ifdef IFU_BTB_PRED_EN
  assign pred_take = pred_jmp_i;
  assign next_pc   = pred_jmp_i ? pred_target_i : fpc_q + XLEN'(4);
`else
  logic unused_pred;
  assign unused_pred = ^{pred_jmp_i, pred_target_i};
  assign pred_take   = 1'b0;
  assign next_pc     = fpc_q + XLEN'(4);
`endif

  assign advance = (hold_code_i == HOLD_CODE_NOPE);
  // Only a REQ-state ack with no coincident redirect yields a usable instruction.
  assign ack_ok  = (state_q == ST_REQ) && if_ack_i && !redirect_en_i;

  assign ack_entry = '{valid: 1'b1, inst: if_data_i, pc: fpc_q, pred: pred_take};
  assign bubble    = '{valid: 1'b0, inst: NOP_INST, pc: out_q.pc, pred: 1'b0};

  // Output register and skid buffer; redirect flushes both ahead of hold.
  always_comb begin
    skid_d = skid_q;
    out_d  = out_q;
    if (redirect_en_i) begin
      skid_d.valid = 1'b0;
      out_d        = bubble;
    end else if (advance) begin
      if (skid_q.valid) begin
        out_d  = skid_q;
        skid_d = ack_entry;
        skid_d.valid = ack_ok;
      end else if (ack_ok) begin
        out_d = ack_entry;
      end else begin
        out_d = bubble;
      end
    end else if (ack_ok) begin
      skid_d = ack_entry;
    end
  end

  // Fetch FSM: the request address never changes while a request is outstanding.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect_en_i) fpc_d = redirect_pc_i;
      end
      ST_REQ: begin
        if (redirect_en_i) begin
          if (if_ack_i) begin
            fpc_d = redirect_pc_i;
          end else begin
            pend_d  = redirect_pc_i;
            state_d = ST_DROP;
          end
        end else if (if_ack_i) begin
          fpc_d = next_pc;
          if (skid_d.valid) state_d = ST_STALL;
        end
      end
      ST_DROP: begin
        if (redirect_en_i) pend_d = redirect_pc_i;
        if (if_ack_i) begin
          fpc_d   = redirect_en_i ? redirect_pc_i : pend_q;
          state_d = ST_REQ;
        end
      end
      ST_STALL: begin
        if (redirect_en_i) begin
          fpc_d   = redirect_pc_i;
          state_d = ST_REQ;
        end else if (advance) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ) || (state_d == ST_DROP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      pend_q  <= RESET_PC;
      req_q   <= 1'b0;
      skid_q  <= '{valid: 1'b0, inst: NOP_INST, pc: '0, pred: 1'b0};
      out_q   <= '{valid: 1'b0, inst: NOP_INST, pc: '0, pred: 1'b0};
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      skid_q  <= skid_d;
      out_q   <= out_d;
    end
  end

  assign pc_o         = fpc_q;
  assign if_addr_o    = fpc_q;
  assign if_req_o     = req_q;
  assign inst_valid_o = out_q.valid;
  assign inst_o       = out_q.inst;
  assign inst_pc_o    = out_q.pc;
  assign inst_pred_o  = out_q.pred;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed fetch/redirect/hold/reset scenarios, then a randomized
// phase checked against an instruction-stream model (next PC = pc+4 or BTB target).
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hold_code_i;
  logic        redirect_en_i;
  logic [31:0] redirect_pc_i;
  logic        pred_jmp_i;
  logic [31:0] pred_target_i;
  logic [31:0] pc_o;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        if_ack_i;
  logic [31:0] if_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_pred_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned btb_mode = 0;

  if_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hold_code_i(hold_code_i),
    .redirect_en_i(redirect_en_i), .redirect_pc_i(redirect_pc_i),
    .pred_jmp_i(pred_jmp_i), .pred_target_i(pred_target_i),
    .pc_o(pc_o), .if_req_o(if_req_o), .if_addr_o(if_addr_o),
    .if_ack_i(if_ack_i), .if_data_i(if_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_pred_o(inst_pred_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3C3_0001;
  endfunction

  function automatic logic btb_hit(input logic [31:0] pc);
    if (btb_mode == 1) return pc == 32'h8000_0008;
    if (btb_mode == 2) return pc[6:2] == 5'd9;
    return 1'b0;
  endfunction

  function automatic logic [31:0] btb_tgt(input logic [31:0] pc);
    if (btb_mode == 1) return 32'h8000_0100;
    return pc + 32'h0000_0120;
  endfunction

  function automatic logic exp_pred(input logic [31:0] pc);
`ifdef IFU_BTB_PRED_EN
    return btb_hit(pc);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_succ(input logic [31:0] pc);
    if (exp_pred(pc)) return btb_tgt(pc);
    return pc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs follow the registered outputs; the BTB and memory answer for the current pc_o.
  task automatic apply(input bit ack_en, input logic [2:0] hold, input bit redir, input logic [31:0] rpc);
    hold_code_i   = hold;
    redirect_en_i = redir;
    redirect_pc_i = rpc;
    pred_jmp_i    = btb_hit(pc_o);
    pred_target_i = btb_tgt(pc_o);
    if_ack_i      = if_req_o & ack_en;
    if_data_i     = if_ack_i ? mem_f(if_addr_o) : 32'($urandom);
  endtask

  task automatic cyc(input bit ack_en, input logic [2:0] hold, input bit redir, input logic [31:0] rpc);
    apply(ack_en, hold, redir, rpc);
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc_o, RESET_PC);
    chk1({tag, "_req"}, if_req_o, 1'b0);
    chk1({tag, "_valid"}, inst_valid_o, 1'b0);
    chk({tag, "_inst"}, inst_o, NOP_INST);
    chk({tag, "_ipc"}, inst_pc_o, 32'h0);
    chk1({tag, "_pred"}, inst_pred_o, 1'b0);
  endtask

  logic        p_valid, p_pred, p_req, p_ack;
  logic [31:0] p_inst, p_pc, p_addr;
  logic [2:0]  r_hold;
  bit          r_redir, r_ack;
  logic [31:0] r_rpc;
  logic [31:0] exp_next;
  int unsigned delivered;

  initial begin
    rst_n = 1'b0;
    hold_code_i = '0; redirect_en_i = 1'b0; redirect_pc_i = '0;
    pred_jmp_i = 1'b0; pred_target_i = '0; if_ack_i = 1'b0; if_data_i = '0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_reset("reset");

    // Reset release: IDLE one cycle, then back-to-back fetches with ack tied to req.
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk1("first_req", if_req_o, 1'b1);
    chk("first_addr", if_addr_o, 32'h8000_0000);
    cyc(1, 0, 0, 0);
    chk1("seq0_valid", inst_valid_o, 1'b1);
    chk("seq0_pc", inst_pc_o, 32'h8000_0000);
    chk("seq0_inst", inst_o, mem_f(32'h8000_0000));
    chk1("seq0_pred", inst_pred_o, 1'b0);
    chk("seq0_addr", if_addr_o, 32'h8000_0004);
    btb_mode = 1;
    cyc(1, 0, 0, 0);
    chk("seq1_pc", inst_pc_o, 32'h8000_0004);
    chk("seq1_addr", if_addr_o, 32'h8000_0008);
    cyc(1, 0, 0, 0);
    chk("seq2_pc", inst_pc_o, 32'h8000_0008);
`ifdef IFU_BTB_PRED_EN
    chk("pred_next_addr", if_addr_o, 32'h8000_0100);
    chk1("pred_tag", inst_pred_o, 1'b1);
`else
    chk("pred_next_addr", if_addr_o, 32'h8000_000C);
    chk1("pred_tag", inst_pred_o, 1'b0);
`endif
    btb_mode = 0;

    // Redirect coincident with ack: new PC requested on the very next cycle.
    cyc(1, 0, 1, 32'h8000_0010);
    chk1("rda_valid", inst_valid_o, 1'b0);
    chk("rda_inst", inst_o, NOP_INST);
    chk("rda_addr", if_addr_o, 32'h8000_0010);

    // Redirect during a slow request: address held until ack, data dropped.
    cyc(0, 0, 1, 32'h8000_0400);
    chk1("drop_valid", inst_valid_o, 1'b0);
    chk("drop_addr0", if_addr_o, 32'h8000_0010);
    chk1("drop_req", if_req_o, 1'b1);
    cyc(0, 0, 0, 0);
    chk("drop_addr1", if_addr_o, 32'h8000_0010);
    cyc(0, 0, 0, 0);
    chk("drop_addr2", if_addr_o, 32'h8000_0010);
    cyc(1, 0, 0, 0);
    chk("drop_newaddr", if_addr_o, 32'h8000_0400);
    chk1("drop_discard", inst_valid_o, 1'b0);
    cyc(1, 0, 0, 0);
    chk1("after_drop_valid", inst_valid_o, 1'b1);
    chk("after_drop_pc", inst_pc_o, 32'h8000_0400);
    chk("after_drop_inst", inst_o, mem_f(32'h8000_0400));

    // Hold for 4 cycles with acks offered: skid fills, request drops, output frozen.
    cyc(1, 3'd1, 0, 0);
    chk1("stall_req", if_req_o, 1'b0);
    chk("stall_out_pc", inst_pc_o, 32'h8000_0400);
    chk("stall_addr", if_addr_o, 32'h8000_0408);
    cyc(1, 3'd2, 0, 0);
    cyc(1, 3'd5, 0, 0);
    cyc(1, 3'd7, 0, 0);
    chk1("stall_req_end", if_req_o, 1'b0);
    chk1("stall_valid_end", inst_valid_o, 1'b1);
    chk("stall_pc_end", inst_pc_o, 32'h8000_0400);
    cyc(1, 0, 0, 0);
    chk("skid_out_pc", inst_pc_o, 32'h8000_0404);
    chk("skid_out_inst", inst_o, mem_f(32'h8000_0404));
    chk1("resume_req", if_req_o, 1'b1);
    chk("resume_addr", if_addr_o, 32'h8000_0408);
    cyc(1, 0, 0, 0);
    chk("resume_pc0", inst_pc_o, 32'h8000_0408);
    cyc(1, 0, 0, 0);
    chk("resume_pc1", inst_pc_o, 32'h8000_040C);

    // Redirect and ack together while held: flush, then fetch from redirect PC.
    cyc(1, 3'd1, 1, 32'h8000_0800);
    chk1("rdh_valid", inst_valid_o, 1'b0);
    chk("rdh_inst", inst_o, NOP_INST);
    chk("rdh_addr", if_addr_o, 32'h8000_0800);
    cyc(1, 0, 0, 0);
    chk("rdh_pc", inst_pc_o, 32'h8000_0800);

    // Redirect in STALL with a full skid buffer: skid content must vanish.
    cyc(1, 3'd1, 0, 0);
    chk1("skid2_req", if_req_o, 1'b0);
    cyc(0, 3'd1, 1, 32'h8000_0C00);
    chk1("skidfl_valid", inst_valid_o, 1'b0);
    chk("skidfl_addr", if_addr_o, 32'h8000_0C00);
    cyc(0, 0, 0, 0);
    chk1("skidfl_empty", inst_valid_o, 1'b0);
    cyc(1, 0, 0, 0);
    chk("skidfl_pc", inst_pc_o, 32'h8000_0C00);

    // Reset while in DROP.
    cyc(0, 0, 1, 32'h8000_1000);
    chk("predrop_addr", if_addr_o, 32'h8000_0C04);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    chk_reset("drop_reset");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk1("restart_req", if_req_o, 1'b1);
    chk("restart_addr", if_addr_o, RESET_PC);

    // Randomized phase against the instruction-stream model.
    btb_mode  = 2;
    exp_next  = RESET_PC;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      r_hold  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      r_redir = ($urandom_range(0, 24) == 0);
      r_rpc   = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      r_ack   = ($urandom_range(0, 4) < 3);
      apply(r_ack, r_hold, r_redir, r_rpc);
      p_valid = inst_valid_o; p_inst = inst_o; p_pc = inst_pc_o; p_pred = inst_pred_o;
      p_req = if_req_o; p_ack = if_ack_i; p_addr = if_addr_o;
      tick();
      if (p_req && !p_ack) begin
        chk1("rnd_req_kept", if_req_o, 1'b1);
        chk("rnd_addr_stable", if_addr_o, p_addr);
      end
      if (r_redir) begin
        chk1("rnd_flush", inst_valid_o, 1'b0);
        exp_next = r_rpc;
      end else if (r_hold != 3'd0) begin
        chk1("rnd_hold_valid", inst_valid_o, p_valid);
        chk("rnd_hold_inst", inst_o, p_inst);
        chk("rnd_hold_pc", inst_pc_o, p_pc);
        chk1("rnd_hold_pred", inst_pred_o, p_pred);
      end else if (p_valid) begin
        chk("rnd_stream_pc", p_pc, exp_next);
        chk("rnd_stream_inst", p_inst, mem_f(p_pc));
        chk1("rnd_stream_pred", p_pred, exp_pred(p_pc));
        exp_next = exp_succ(p_pc);
        delivered++;
      end
    end
    chk1("rnd_progress", delivered > 300, 1'b1);

    // PC+4 wraps modulo 2^32.
    btb_mode = 0;
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr0", if_addr_o, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_addr1", if_addr_o, 32'h0000_0000);
    chk("wrap_out_pc", inst_pc_o, 32'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
